// File: rtl/somador_pkg.sv
// Shared definitions for the somador adder: default width and a golden
// {cout,sum} reference used when checking adder results.
package somador_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int REF_MAX_WIDTH = 32;

  // Operands must be zero-extended to REF_MAX_WIDTH; carry lands in bit width.
  function automatic logic [REF_MAX_WIDTH:0] ref_add(
    input logic [REF_MAX_WIDTH-1:0] a,
    input logic [REF_MAX_WIDTH-1:0] b,
    input logic                     cin
  );
    logic [REF_MAX_WIDTH:0] total;
    total = {1'b0, a} + {1'b0, b} + {{REF_MAX_WIDTH{1'b0}}, cin};
    return total;
  endfunction

endpackage

// File: rtl/somador_bit.sv
// Combinational 1-bit full adder cell, chained by somador to build wider adders.
module somador_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic propagate;

  assign propagate = a_i ^ b_i;
  assign s_o       = propagate ^ cin_i;
  assign cout_o    = (a_i & b_i) | (cin_i & propagate);

endmodule

// File: rtl/somador.sv
// Registered ripple-carry adder: {Cout,Soma} <= A + B + Cin with one cycle
// of latency and a synchronous active-low reset.
module somador
  import somador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Soma,
  output logic             Cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] soma_q, soma_d;
  logic             cout_q, cout_d;

  assign carry[0] = Cin;

  // Carry ripples from the LSB cell towards the MSB cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    somador_bit u_bit (
      .a_i    (A[i]),
      .b_i    (B[i]),
      .cin_i  (carry[i]),
      .s_o    (sum[i]),
      .cout_o (carry[i+1])
    );
  end

  always_comb begin
    soma_d = sum;
    cout_d = carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      soma_q <= '0;
      cout_q <= 1'b0;
    end else begin
      soma_q <= soma_d;
      cout_q <= cout_d;
    end
  end

  assign Soma = soma_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_somador.sv
// Self-checking bench for somador at WIDTH=1, 4 and 8, with an arithmetic
// reference model checked every cycle plus directed literal expectations.
module tb_somador;
  import somador_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       cin;
  logic [0:0] soma1;
  logic [3:0] soma4;
  logic [7:0] soma8;
  logic       cout1, cout4, cout8;

  int checks   = 0;
  int failures = 0;

  logic       modelValid = 1'b0;
  logic [1:0] exp1;
  logic [4:0] exp4;
  logic [8:0] exp8;

  somador #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin), .Soma(soma1), .Cout(cout1)
  );
  somador #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin), .Soma(soma4), .Cout(cout4)
  );
  somador #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin), .Soma(soma8), .Cout(cout8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what each adder must hold after every rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp1 <= '0;
      exp4 <= '0;
      exp8 <= '0;
    end else begin
      exp1 <= 2'(int'(a1) + int'(b1) + int'(cin));
      exp4 <= 5'(int'(a4) + int'(b4) + int'(cin));
      exp8 <= 9'(int'(a8) + int'(b8) + int'(cin));
    end
    modelValid <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model w1", {7'b0, cout1, soma1}, {7'b0, exp1});
      checkOutput("model w4", {4'b0, cout4, soma4}, {4'b0, exp4});
      checkOutput("model w8", {cout8, soma8}, exp8);
    end
  end

  // Drives all three adders from one 8-bit vector, then steps past the edge.
  task automatic applyStimulus(input logic rst, input logic [7:0] a, input logic [7:0] b,
                               input logic c);
    @(negedge clk);
    rst_n = rst;
    a1 = a[0:0];
    b1 = b[0:0];
    a4 = a[3:0];
    b4 = b[3:0];
    a8 = a;
    b8 = b;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] vecs   [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  logic [1:0] vecExp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [REF_MAX_WIDTH:0] r;
    rst_n = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0; cin = 1'b0;

    applyStimulus(1'b0, 8'h01, 8'h01, 1'b1);
    checkOutput("reset w1", {7'b0, cout1, soma1}, 9'h000);
    checkOutput("reset w8", {cout8, soma8}, 9'h000);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = vecs[i];
      applyStimulus(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0]);
      checkOutput($sformatf("w1 truth %0d", i), {7'b0, cout1, soma1}, {7'b0, vecExp[i]});
    end

    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b1);
    checkOutput("w8 wrap", {cout8, soma8}, 9'h100);
    checkOutput("w4 wrap", {4'b0, cout4, soma4}, 9'h010);

    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
    checkOutput("w8 max", {cout8, soma8}, 9'h1FF);
    checkOutput("w4 max", {4'b0, cout4, soma4}, 9'h01F);

    applyStimulus(1'b1, 8'h3C, 8'h0F, 1'b0);
    checkOutput("stream before reset", {cout8, soma8}, 9'h04B);
    applyStimulus(1'b0, 8'h3C, 8'h0F, 1'b0);
    checkOutput("mid-stream reset", {cout8, soma8}, 9'h000);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 1'b0);
    checkOutput("after reset release", {cout8, soma8}, 9'h04B);

    r = ref_add(32'hFF, 32'h00, 1'b1);
    checkOutput("ref_add wrap", r[8:0], 9'h100);
    r = ref_add(32'h3C, 32'h0F, 1'b0);
    checkOutput("ref_add stream", r[8:0], 9'h04B);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
